lcd_timing_fsm: RTL



---
 rtl/lcd_pkg.sv | 33 +++
 rtl/lcd_delay_counter.sv | 33 +++
 rtl/lcd_timing_fsm.sv | 118 +++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD controller: state encoding, default 50 MHz timing
// constants and the HD44780 command bytes used by the main LCD FSM.
package lcd_pkg;

   typedef logic [3:0] lcd_state_t;

   localparam lcd_state_t S_IDLE    = 4'd0;
   localparam lcd_state_t S_SETUP_H = 4'd1;
   localparam lcd_state_t S_PULSE_H = 4'd2;
   localparam lcd_state_t S_HOLD_H  = 4'd3;
   localparam lcd_state_t S_GAP     = 4'd4;
   localparam lcd_state_t S_SETUP_L = 4'd5;
   localparam lcd_state_t S_PULSE_L = 4'd6;
   localparam lcd_state_t S_HOLD_L  = 4'd7;
   localparam lcd_state_t S_WAIT    = 4'd8;
   localparam lcd_state_t S_DONE    = 4'd9;

   // Cycle counts at 50 MHz
   localparam int unsigned DEF_T_SETUP = 2;
   localparam int unsigned DEF_T_PULSE = 12;
   localparam int unsigned DEF_T_HOLD  = 1;
   localparam int unsigned DEF_T_GAP   = 50;
   localparam int unsigned DEF_T_WAIT  = 2000;
   localparam int unsigned CLEAR_WAIT  = 82000;

   localparam logic [7:0] FUNCTION_SET = 8'h28;
   localparam logic [7:0] DISPLAY_OFF  = 8'h08;
   localparam logic [7:0] ENTRY_MODE   = 8'h06;
   localparam logic [7:0] CLEAR        = 8'h01;
   localparam logic [7:0] DISPLAY_ON   = 8'h0C;
   localparam logic [7:0] HOME         = 8'h02;

endpackage

// File: rtl/lcd_delay_counter.sv
// Loadable down-counter that stops at zero; zero is flagged combinationally from the register.
module lcd_delay_counter #(
   parameter int unsigned CW = 12
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   output logic          zero
);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/lcd_timing_fsm.sv
// Drives one latched byte onto the 4-bit LCD bus as two timed nibbles, then pulses TM
// once the LCD has had its execution time.
module lcd_timing_fsm
   import lcd_pkg::*;
#(
   parameter int unsigned T_SETUP = DEF_T_SETUP,
   parameter int unsigned T_PULSE = DEF_T_PULSE,
   parameter int unsigned T_HOLD  = DEF_T_HOLD,
   parameter int unsigned T_GAP   = DEF_T_GAP,
   parameter int unsigned T_WAIT  = DEF_T_WAIT,
   parameter int unsigned CW      = 12
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       INITM,
   input  logic       RS_IN,
   input  logic [7:0] BYTE,
   output logic       TM,
   output logic       BUSY,
   output logic       LCD_E,
   output logic       LCD_RS,
   output logic       LCD_RW,
   output logic [3:0] SF_D
);

   localparam logic [CW-1:0] LD_SETUP = CW'(T_SETUP - 1);
   localparam logic [CW-1:0] LD_PULSE = CW'(T_PULSE - 1);
   localparam logic [CW-1:0] LD_HOLD  = CW'(T_HOLD - 1);
   localparam logic [CW-1:0] LD_GAP   = CW'(T_GAP - 1);
   localparam logic [CW-1:0] LD_WAIT  = CW'(T_WAIT - 1);

   lcd_state_t    state_q, state_d;
   logic [7:0]    byte_q, byte_d;
   logic          rs_q, rs_d;
   logic          load;
   logic [CW-1:0] load_val;
   logic          zero;

   lcd_delay_counter #(
      .CW(CW)
   ) u_delay (
      .clk     (CLK),
      .rst_n   (RST_N),
      .load    (load),
      .load_val(load_val),
      .zero    (zero)
   );

   // Every timed state exits on the zero edge and loads the next state's duration.
   always_comb begin
      state_d  = state_q;
      byte_d   = byte_q;
      rs_d     = rs_q;
      load     = 1'b0;
      load_val = '0;
      case (state_q)
         S_IDLE: if (INITM) begin
            state_d  = S_SETUP_H;
            byte_d   = BYTE;
            rs_d     = RS_IN;
            load     = 1'b1;
            load_val = LD_SETUP;
         end
         S_SETUP_H: if (zero) begin state_d = S_PULSE_H; load = 1'b1; load_val = LD_PULSE; end
         S_PULSE_H: if (zero) begin state_d = S_HOLD_H;  load = 1'b1; load_val = LD_HOLD;  end
         S_HOLD_H:  if (zero) begin state_d = S_GAP;     load = 1'b1; load_val = LD_GAP;   end
         S_GAP:     if (zero) begin state_d = S_SETUP_L; load = 1'b1; load_val = LD_SETUP; end
         S_SETUP_L: if (zero) begin state_d = S_PULSE_L; load = 1'b1; load_val = LD_PULSE; end
         S_PULSE_L: if (zero) begin state_d = S_HOLD_L;  load = 1'b1; load_val = LD_HOLD;  end
         S_HOLD_L:  if (zero) begin state_d = S_WAIT;    load = 1'b1; load_val = LD_WAIT;  end
         S_WAIT:    if (zero) state_d = S_DONE;
         S_DONE:    state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so the registered pins line up with the state.
   logic       upper, lower;
   logic [3:0] sf_next;

   always_comb begin
      upper = (state_d == S_SETUP_H) || (state_d == S_PULSE_H) ||
              (state_d == S_HOLD_H)  || (state_d == S_GAP);
      lower = (state_d == S_SETUP_L) || (state_d == S_PULSE_L) ||
              (state_d == S_HOLD_L)  || (state_d == S_WAIT);
      sf_next = 4'h0;
      if (upper) begin
         sf_next = byte_d[7:4];
      end else if (lower) begin
         sf_next = byte_d[3:0];
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= S_IDLE;
         byte_q  <= 8'h00;
         rs_q    <= 1'b0;
         TM      <= 1'b0;
         BUSY    <= 1'b0;
         LCD_E   <= 1'b0;
         LCD_RS  <= 1'b0;
         SF_D    <= 4'h0;
      end else begin
         state_q <= state_d;
         byte_q  <= byte_d;
         rs_q    <= rs_d;
         TM      <= (state_d == S_DONE);
         BUSY    <= (state_d != S_IDLE);
         LCD_E   <= (state_d == S_PULSE_H) || (state_d == S_PULSE_L);
         LCD_RS  <= (upper || lower) && rs_d;
         SF_D    <= sf_next;
      end
   end

   assign LCD_RW = 1'b0;

endmodule
